fifo_ff_sync_p: RTL and testbench

Parametrised single-clock flip-flop FIFO. It supersedes the separate combinational-read and registered-read sync FIFOs with one block, where the read mode is chosen by parameter.
- Adds non-power-of-2 depth.
- Adds programmable almost-full and almost-empty thresholds.
- Adds a synchronous flush.
- Adds sticky overflow and underflow error flags.
- Sits between producer and consumer logic in one clock domain, and is also the DUT of the common FIFO bench.

---
 rtl/fifo_ff_pkg.sv | 20 ++
 rtl/fifo_ff_ptr.sv | 47 ++++
 rtl/fifo_ff_sync_p.sv | 149 ++++++++++++++
 tb/tb_fifo_ff_sync_p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ff_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ff_pkg
// Shared types and helpers for the flip-flop synchronous FIFO family.
//   rd_mode_e    : read-port flavour (RD_COMB show-ahead, RD_REG registered)
//   fifo_addr_w  : pointer width for a given depth, never below 1 bit
// -----------------------------------------------------------------------------
package fifo_ff_pkg;

    typedef enum logic {
        RD_COMB = 1'b0,
        RD_REG  = 1'b1
    } rd_mode_e;

    function automatic int fifo_addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : fifo_ff_pkg

// File: rtl/fifo_ff_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ff_ptr
// Circular pointer that wraps from DEPTH-1 back to 0, so depths that are not a
// power of two never alias onto unused addresses.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (pointer -> 0)
//   clr_i  in   synchronous clear (flush), same effect as reset
//   inc_i  in   advance by one entry
//   ptr_o  out  current pointer value
// -----------------------------------------------------------------------------
module fifo_ff_ptr #(
    parameter int DEPTH = 8,
    parameter int ADDR  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [ADDR-1:0] ptr_o
);

    localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

    logic [ADDR-1:0] ptr_q;
    logic [ADDR-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ff_ptr

// File: rtl/fifo_ff_sync_p.sv
// -----------------------------------------------------------------------------
// fifo_ff_sync_p
// Single-clock flip-flop FIFO with any depth >= 2, selectable read mode,
// programmable almost-full / almost-empty thresholds, synchronous flush and
// sticky overflow / underflow flags.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset, highest priority
//   flush         in   synchronous queue clear (storage and error flags kept)
//   wr_data       in   write data
//   wr_en         in   push request (ignored while full)
//   rd_en         in   pop request (ignored while empty)
//   rd_data       out  RD_COMB: head entry; RD_REG: entry captured on last pop
//   empty         out  occup == 0
//   full          out  occup == DEPTH
//   almost_full   out  occup >= AF_LVL
//   almost_empty  out  occup <= AE_LVL
//   occup         out  number of stored entries
//   ovf           out  sticky: push attempted while full
//   udf           out  sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module fifo_ff_sync_p
    import fifo_ff_pkg::*;
#(
    parameter int       WIDTH   = 8,
    parameter int       DEPTH   = 8,
    parameter int       ADDR    = fifo_addr_w(DEPTH),
    parameter rd_mode_e RD_MODE = RD_COMB,
    parameter int       AF_LVL  = DEPTH - 1,
    parameter int       AE_LVL  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    occup,
    output logic             ovf,
    output logic             udf
);

    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_af_range
        $error("fifo_ff_sync_p: AF_LVL must lie in 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_ae_range
        $error("fifo_ff_sync_p: AE_LVL must lie in 0..DEPTH-1");
    end

    localparam logic [ADDR:0] DEPTH_C = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] AF_C    = (ADDR + 1)'(AF_LVL);
    localparam logic [ADDR:0] AE_C    = (ADDR + 1)'(AE_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR:0]    occup_q, occup_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [ADDR-1:0]  wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    // Flags decode the registered count directly.
    assign empty        = (occup_q == '0);
    assign full         = (occup_q == DEPTH_C);
    assign almost_full  = (occup_q >= AF_C);
    assign almost_empty = (occup_q <= AE_C);
    assign occup        = occup_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

    // Flush swallows same-cycle requests, so they neither move data nor
    // raise the error flags.
    assign push_ok = wr_en & ~full  & ~flush;
    assign pop_ok  = rd_en & ~empty & ~flush;

    always_comb begin
        occup_d = occup_q;
        ovf_d   = ovf_q | (wr_en & full  & ~flush);
        udf_d   = udf_q | (rd_en & empty & ~flush);
        if (flush) begin
            occup_d = '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   occup_d = occup_q + (ADDR + 1)'(1);
                2'b01:   occup_d = occup_q - (ADDR + 1)'(1);
                default: occup_d = occup_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occup_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            occup_q <= occup_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    fifo_ff_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (push_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ff_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr)
    );

    if (RD_MODE == RD_REG) begin : g_rd_reg
        logic [WIDTH-1:0] rd_q;
        // Captures the head on an accepted pop and holds through flush and
        // rejected pops.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (pop_ok) begin
                rd_q <= mem_q[rd_ptr];
            end
        end
        assign rd_data = rd_q;
    end else begin : g_rd_comb
        assign rd_data = mem_q[rd_ptr];
    end

endmodule : fifo_ff_sync_p

// File: tb/tb_fifo_ff_sync_p.sv
module tb_fifo_ff_sync_p;
    import fifo_ff_pkg::*;

    localparam int W = 8;
    localparam int D = 6;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;

    logic [W-1:0] c_rd, r_rd;
    logic         c_empty, c_full, c_af, c_ae, c_ovf, c_udf;
    logic         r_empty, r_full, r_af, r_ae, r_ovf, r_udf;
    logic [A:0]   c_occ, r_occ;

    always #5 clk = ~clk;

    fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .RD_MODE(RD_COMB)) u_comb (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .rd_en(rd_en), .rd_data(c_rd), .empty(c_empty), .full(c_full),
        .almost_full(c_af), .almost_empty(c_ae), .occup(c_occ),
        .ovf(c_ovf), .udf(c_udf)
    );

    fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .RD_MODE(RD_REG)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .rd_en(rd_en), .rd_data(r_rd), .empty(r_empty), .full(r_full),
        .almost_full(r_af), .almost_empty(r_ae), .occup(r_occ),
        .ovf(r_ovf), .udf(r_udf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored words plus sticky flags and the
    // last popped word (registered read port).
    bit [7:0] mq[$];
    bit       m_ovf = 0, m_udf = 0;
    bit [7:0] m_rreg = 0;

    typedef struct {
        bit       wr;
        bit [7:0] wd;
        bit       rd;
        int       occ;
        bit       full;
        bit       af;
        bit       ovf;
        bit       udf;
        bit       chk_c;
        bit [7:0] rdc;
        bit [7:0] rdr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic drive(input bit w, input bit [7:0] wd, input bit r, input bit f, input bit rs);
        bit pre_full, pre_empty;
        wr_en = w; wr_data = wd; rd_en = r; flush = f; rst = rs;
        pre_full  = (mq.size() == D);
        pre_empty = (mq.size() == 0);
        if (rs) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_rreg = 0;
        end else if (f) begin
            mq.delete();
        end else begin
            if (w && pre_full)  m_ovf = 1;
            if (r && pre_empty) m_udf = 1;
            if (r && !pre_empty) m_rreg = mq.pop_front();
            if (w && !pre_full) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; flush = 0; rst = 0;
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("occup_c", 32'(c_occ), 32'(n));
        chk("occup_r", 32'(r_occ), 32'(n));
        chk("empty", 32'(c_empty), 32'(n == 0));
        chk("full", 32'(c_full), 32'(n == D));
        chk("almost_full", 32'(c_af), 32'(n >= D - 1));
        chk("almost_empty", 32'(c_ae), 32'(n <= 1));
        chk("ovf", 32'({c_ovf, r_ovf}), 32'({m_ovf, m_ovf}));
        chk("udf", 32'({c_udf, r_udf}), 32'({m_udf, m_udf}));
        chk("rd_reg", 32'(r_rd), 32'(m_rreg));
        if (n > 0) chk("rd_comb", 32'(c_rd), 32'(mq[0]));
    endtask

    function automatic vec_t mk(bit wr, bit [7:0] wd, bit rd, int occ, bit ovf, bit udf,
                                bit chk_c, bit [7:0] rdc, bit [7:0] rdr);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.occ = occ;
        v.full = (occ == 6); v.af = (occ >= 5);
        v.ovf = ovf; v.udf = udf; v.chk_c = chk_c; v.rdc = rdc; v.rdr = rdr;
        return v;
    endfunction

    initial begin
        // Directed table: fill, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= 6; i++)
            vt.push_back(mk(1, 8'(i * 8'h11), 0, i, 0, 0, 1, 8'h11, 8'h00));
        vt.push_back(mk(1, 8'h77, 0, 6, 1, 0, 1, 8'h11, 8'h00));
        for (int i = 1; i <= 6; i++)
            vt.push_back(mk(0, 8'h00, 1, 6 - i, 1, 0, (i < 6), 8'(i * 8'h11 + 8'h11), 8'(i * 8'h11)));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 8'h66));

        // Reset state
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rst_occup", 32'(c_occ), 0);
        chk("rst_empty", 32'({c_empty, r_empty}), 32'b11);
        chk("rst_full", 32'({c_full, r_full}), 0);
        chk("rst_ae_af", 32'({c_ae, c_af}), 32'b10);
        chk("rst_rd", 32'({c_rd, r_rd}), 0);
        chk("rst_err", 32'({c_ovf, c_udf, r_ovf, r_udf}), 0);

        // Tests 1 and 2 from the table
        foreach (vt[k]) begin
            drive(vt[k].wr, vt[k].wd, vt[k].rd, 0, 0);
            chk($sformatf("tbl%0d_occup", k), 32'(c_occ), 32'(vt[k].occ));
            chk($sformatf("tbl%0d_full", k), 32'({c_full, r_full}), 32'({vt[k].full, vt[k].full}));
            chk($sformatf("tbl%0d_af", k), 32'(c_af), 32'(vt[k].af));
            chk($sformatf("tbl%0d_empty", k), 32'(c_empty), 32'(vt[k].occ == 0));
            chk($sformatf("tbl%0d_ovf", k), 32'({c_ovf, r_ovf}), 32'({vt[k].ovf, vt[k].ovf}));
            chk($sformatf("tbl%0d_udf", k), 32'({c_udf, r_udf}), 32'({vt[k].udf, vt[k].udf}));
            if (vt[k].chk_c) chk($sformatf("tbl%0d_rdc", k), 32'(c_rd), 32'(vt[k].rdc));
            chk($sformatf("tbl%0d_rdr", k), 32'(r_rd), 32'(vt[k].rdr));
        end
        drive(0, 0, 0, 0, 0);
        chk("sticky_hold", 32'({c_ovf, c_udf}), 32'b11);

        // Test 3: streaming wrap with occupancy pinned at 1
        drive(0, 0, 0, 0, 1);
        drive(1, 8'h00, 0, 0, 0);
        for (int i = 1; i < 20; i++) begin
            drive(1, 8'(i), 1, 0, 0);
            chk("wrap_occup", 32'(c_occ), 1);
            chk("wrap_head", 32'(c_rd), 32'(i));
            chk("wrap_rdr", 32'(r_rd), 32'(i - 1));
        end
        chk("wrap_err", 32'({c_ovf, c_udf}), 0);

        // Test 4: registered read latency and hold
        drive(0, 0, 0, 0, 1);
        drive(1, 8'hA5, 0, 0, 0);
        drive(1, 8'h5A, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("rreg_n1", 32'(r_rd), 32'hA5);
        drive(0, 0, 0, 0, 0);
        chk("rreg_n2", 32'(r_rd), 32'hA5);
        drive(0, 0, 1, 0, 0);
        chk("rreg_n4", 32'(r_rd), 32'h5A);
        drive(0, 0, 1, 0, 0);
        chk("rreg_rejected_hold", 32'(r_rd), 32'h5A);

        // Test 5: flush swallows same-cycle requests
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 8'(8'hC0 + i), 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 8'hEE, 1, 1, 0);
        chk("flush_occup", 32'(c_occ), 0);
        chk("flush_empty", 32'({c_empty, r_empty}), 32'b11);
        chk("flush_err", 32'({c_ovf, c_udf, r_ovf, r_udf}), 0);
        chk("flush_rreg_hold", 32'(r_rd), 32'hC0);
        drive(1, 8'h3C, 0, 0, 0);
        chk("flush_push_head", 32'(c_rd), 32'h3C);
        drive(0, 0, 1, 0, 0);
        chk("flush_pop", 32'(r_rd), 32'h3C);
        chk("flush_pop_empty", 32'(c_empty), 1);

        // Test 6: reset mid-stream with ovf set
        for (int i = 0; i < 7; i++) drive(1, 8'(8'h90 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        chk("mid_occup", 32'(c_occ), 3);
        chk("mid_ovf", 32'(c_ovf), 1);
        drive(0, 0, 0, 0, 1);
        chk("mid_rst_occup", 32'(c_occ), 0);
        chk("mid_rst_err", 32'({c_ovf, c_udf, r_ovf, r_udf}), 0);
        chk("mid_rst_rd", 32'({c_rd, r_rd}), 0);
        chk("mid_rst_flags", 32'({c_empty, c_ae, c_full, c_af}), 32'b1100);

        // Randomised traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            bit w, r, f, rs;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            f  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 149) == 0);
            drive(w, 8'($urandom), r, f, rs);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_fifo_ff_sync_p
